// File: rtl/wormhole_switch_arbiter_if.sv
// Request, tail and ready inputs plus crossbar selects and pop grants of the 5-port wormhole arbiter.
// The slave modport is the arbiter side; the master modport is the input-buffer/crossbar side.
interface wormhole_switch_arbiter_if #(
    parameter int N_REGISTER = 3,
    parameter int N_BIT_SEL  = 3,
    parameter int N_PORT     = 5
);
    logic [N_REGISTER-1:0] request_L;
    logic [N_REGISTER-1:0] request_N;
    logic [N_REGISTER-1:0] request_E;
    logic [N_REGISTER-1:0] request_S;
    logic [N_REGISTER-1:0] request_W;
    logic [N_PORT-1:0]     tail_in;
    logic [N_PORT-1:0]     out_ready;
    logic [N_BIT_SEL-1:0]  Select_L;
    logic [N_BIT_SEL-1:0]  Select_N;
    logic [N_BIT_SEL-1:0]  Select_E;
    logic [N_BIT_SEL-1:0]  Select_S;
    logic [N_BIT_SEL-1:0]  Select_W;
    logic [N_PORT-1:0]     grant;

    modport slave (
        input  request_L, request_N, request_E, request_S, request_W, tail_in, out_ready,
        output Select_L, Select_N, Select_E, Select_S, Select_W, grant
    );

    modport master (
        output request_L, request_N, request_E, request_S, request_W, tail_in, out_ready,
        input  Select_L, Select_N, Select_E, Select_S, Select_W, grant
    );
endinterface

// File: rtl/wormhole_switch_arbiter.sv
// Per-output round-robin arbiter with wormhole locking; Select follows a request by 1 cycle.
// grant is combinational and drops while the owner's output is not ready; the lock is held meanwhile.
module wormhole_switch_arbiter #(
    parameter int N_REGISTER = 3,
    parameter int N_BIT_SEL  = 3,
    parameter int N_PORT     = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    wormhole_switch_arbiter_if.slave  bus
);
    localparam logic [N_BIT_SEL-1:0] SEL_IDLE = N_BIT_SEL'(N_PORT);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t                state_q [N_PORT];
    state_t                state_d [N_PORT];
    logic [N_BIT_SEL-1:0]  sel_q   [N_PORT];
    logic [N_BIT_SEL-1:0]  sel_d   [N_PORT];
    logic [2:0]            ptr_q   [N_PORT];
    logic [2:0]            ptr_d   [N_PORT];
    logic [N_REGISTER-1:0] req     [N_PORT];
    logic [N_PORT-1:0]     req_vld;
    logic [N_PORT-1:0]     grant_c;

    assign req[0] = bus.request_L;
    assign req[1] = bus.request_N;
    assign req[2] = bus.request_E;
    assign req[3] = bus.request_S;
    assign req[4] = bus.request_W;

    always_comb begin
        req_vld = '0;
        for (int i = 0; i < N_PORT; i++) begin
            req_vld[i] = (req[i] < N_REGISTER'(N_PORT));
        end
    end

    always_comb begin
        logic       found;
        logic [3:0] sum;
        logic [2:0] idx;
        logic [2:0] own;
        grant_c = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        own     = '0;
        for (int o = 0; o < N_PORT; o++) begin
            state_d[o] = state_q[o];
            sel_d[o]   = sel_q[o];
            ptr_d[o]   = ptr_q[o];
            found      = 1'b0;
            case (state_q[o])
                ST_IDLE: begin
                    // Scan candidates starting at the round-robin pointer, wrapping mod N_PORT.
                    for (int k = 0; k < N_PORT; k++) begin
                        sum = {1'b0, ptr_q[o]} + 4'(k);
                        idx = (sum >= 4'(N_PORT)) ? 3'(sum - 4'(N_PORT)) : sum[2:0];
                        if (!found && req_vld[idx] && (req[idx] == N_REGISTER'(o))) begin
                            found      = 1'b1;
                            state_d[o] = ST_LOCKED;
                            sel_d[o]   = N_BIT_SEL'(idx);
                            ptr_d[o]   = (idx == 3'(N_PORT - 1)) ? 3'd0 : idx + 3'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    own = 3'(sel_q[o]);
                    if ((own < 3'(N_PORT)) && (req[own] == N_REGISTER'(o)) && bus.out_ready[o]) begin
                        grant_c[own] = 1'b1;
                        if (bus.tail_in[own]) begin
                            state_d[o] = ST_IDLE;
                            sel_d[o]   = SEL_IDLE;
                        end
                    end
                end
                default: begin
                    state_d[o] = ST_IDLE;
                    sel_d[o]   = SEL_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int o = 0; o < N_PORT; o++) begin
            if (rst) begin
                state_q[o] <= ST_IDLE;
                sel_q[o]   <= SEL_IDLE;
                ptr_q[o]   <= '0;
            end else begin
                state_q[o] <= state_d[o];
                sel_q[o]   <= sel_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

    assign bus.Select_L = sel_q[0];
    assign bus.Select_N = sel_q[1];
    assign bus.Select_E = sel_q[2];
    assign bus.Select_S = sel_q[3];
    assign bus.Select_W = sel_q[4];
    assign bus.grant    = grant_c;
endmodule

// File: tb/tb_wormhole_switch_arbiter.sv
// Directed scenarios and randomized traffic for wormhole_switch_arbiter against an owner/pointer model.
module tb_wormhole_switch_arbiter;
    logic clk;
    logic rst;
    int   reqc [5];
    bit   tl   [5];
    bit   rd   [5];
    int   m_own [5];
    int   m_ptr [5];
    int   checks;
    int   errors;

    wormhole_switch_arbiter_if bus ();

    assign bus.request_L = 3'(reqc[0]);
    assign bus.request_N = 3'(reqc[1]);
    assign bus.request_E = 3'(reqc[2]);
    assign bus.request_S = 3'(reqc[3]);
    assign bus.request_W = 3'(reqc[4]);
    assign bus.tail_in   = {tl[4], tl[3], tl[2], tl[1], tl[0]};
    assign bus.out_ready = {rd[4], rd[3], rd[2], rd[1], rd[0]};

    wormhole_switch_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Output o passes a flit when its owner still asks for o and o is ready.
    function automatic bit owner_moves(int o);
        return (m_own[o] >= 0) && (reqc[m_own[o]] == o) && rd[o];
    endfunction

    function automatic logic [4:0] model_grant();
        logic [4:0] g = '0;
        for (int o = 0; o < 5; o++)
            if (owner_moves(o)) g[m_own[o]] = 1'b1;
        return g;
    endfunction

    function automatic int model_sel(int o);
        return (m_own[o] < 0) ? 5 : m_own[o];
    endfunction

    task automatic sample();
        @(negedge clk);
        chk("grant",    32'(bus.grant),    32'(model_grant()));
        chk("Select_L", 32'(bus.Select_L), 32'(model_sel(0)));
        chk("Select_N", 32'(bus.Select_N), 32'(model_sel(1)));
        chk("Select_E", 32'(bus.Select_E), 32'(model_sel(2)));
        chk("Select_S", 32'(bus.Select_S), 32'(model_sel(3)));
        chk("Select_W", 32'(bus.Select_W), 32'(model_sel(4)));
    endtask

    task automatic tick();
        int nxt_own [5];
        int nxt_ptr [5];
        @(posedge clk);
        for (int o = 0; o < 5; o++) begin
            nxt_own[o] = m_own[o];
            nxt_ptr[o] = m_ptr[o];
            if (rst) begin
                nxt_own[o] = -1;
                nxt_ptr[o] = 0;
            end else if (m_own[o] < 0) begin
                for (int k = 0; k < 5; k++) begin
                    int i = (m_ptr[o] + k) % 5;
                    if (nxt_own[o] < 0 && reqc[i] == o) begin
                        nxt_own[o] = i;
                        nxt_ptr[o] = (i + 1) % 5;
                    end
                end
            end else if (owner_moves(o) && tl[m_own[o]]) begin
                nxt_own[o] = -1;
            end
        end
        m_own = nxt_own;
        m_ptr = nxt_ptr;
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 5; i++) begin
            reqc[i] = 7;
            tl[i]   = 1'b0;
            rd[i]   = 1'b1;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_s [6] = '{0, 5, 2, 5, 4, 5};
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        for (int o = 0; o < 5; o++) begin
            m_own[o] = -1;
            m_ptr[o] = 0;
        end
        idle_inputs();
        tick();
        rst = 1'b0;

        // Reset state.
        sample();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_selL", 32'(bus.Select_L), 32'd5);
        tick();

        // Single request E->N, then tail release with a one-cycle bubble.
        do_reset();
        reqc[2] = 1;
        sample(); tick();
        sample();
        chk("single_selN", 32'(bus.Select_N), 32'd2);
        chk("single_grant", 32'(bus.grant), 32'b00100);
        tick();
        tl[2] = 1'b1;
        sample(); tick();
        tl[2] = 1'b0;
        sample();
        chk("single_rel_selN", 32'(bus.Select_N), 32'd5);
        chk("single_rel_grant", 32'(bus.grant), 32'd0);
        tick();
        reqc[2] = 7;
        tick();

        // Contention on S with single-flit packets.
        do_reset();
        reqc[0] = 3; reqc[2] = 3; reqc[4] = 3;
        for (int i = 0; i < 5; i++) tl[i] = 1'b1;
        sample(); tick();
        for (int k = 0; k < 6; k++) begin
            sample();
            chk("contend_selS", 32'(bus.Select_S), 32'(exp_s[k]));
            tick();
            if (k == 4) begin
                reqc[0] = 7; reqc[2] = 7; reqc[4] = 7;
            end
        end
        reqc[0] = 3; reqc[2] = 3;
        sample(); tick();
        sample();
        chk("contend2_selS", 32'(bus.Select_S), 32'd0);
        tick();
        idle_inputs();
        tick();

        // Backpressure on N->E.
        do_reset();
        reqc[1] = 2;
        sample(); tick();
        sample();
        chk("bp_lock_selE", 32'(bus.Select_E), 32'd1);
        tick();
        rd[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("bp_grantN", 32'(bus.grant[1]), 32'd0);
            chk("bp_selE", 32'(bus.Select_E), 32'd1);
            tick();
        end
        rd[2] = 1'b1;
        sample();
        chk("bp_resume_grantN", 32'(bus.grant[1]), 32'd1);
        tick();

        // Parallel L->E and N->W.
        do_reset();
        reqc[0] = 2; reqc[1] = 4;
        sample(); tick();
        sample();
        chk("par_selE", 32'(bus.Select_E), 32'd0);
        chk("par_selW", 32'(bus.Select_W), 32'd1);
        chk("par_grant", 32'(bus.grant), 32'b00011);
        tick();

        // Reset while W->L is mid-packet.
        do_reset();
        reqc[4] = 0;
        sample(); tick();
        sample();
        chk("mid_selL", 32'(bus.Select_L), 32'd4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        chk("mid_rst_selL", 32'(bus.Select_L), 32'd5);
        chk("mid_rst_grant", 32'(bus.grant), 32'd0);
        tick();
        sample();
        chk("mid_relock_selL", 32'(bus.Select_L), 32'd4);
        tick();

        // Invalid request codes never lock.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            reqc[3] = (k % 2 == 0) ? 6 : 7;
            reqc[1] = 5;
            sample();
            chk("inv_grant", 32'(bus.grant), 32'd0);
            chk("inv_selS", 32'(bus.Select_S), 32'd5);
            tick();
        end

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 5; i++) begin
                reqc[i] = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
                tl[i]   = ($urandom_range(0, 3) == 0);
                rd[i]   = ($urandom_range(0, 4) != 0);
            end
            rst = ($urandom_range(0, 59) == 0);
            sample();
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
